// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment patterns, scan FSM states and anode helpers
package seg_pkg;

  // Active-low segment patterns, bit order g..a (seg[6]=g, seg[0]=a)
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Per-dwell capture FSM
  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_t;

  // True when exactly one anode is driven (low)
  function automatic logic an_onehot_low(input logic [3:0] an);
    logic r;
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Digit slot selected by a one-hot-low anode vector
  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] r;
    case (an)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational seven-segment pattern to hex nibble decoder
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_blank,
  output logic       o_minus,
  output logic       o_err
);

  // Map each legal pattern back to its nibble; blank/minus/invalid give nibble 0
  always_comb begin
    o_nibble = 4'h0;
    o_blank  = 1'b0;
    o_minus  = 1'b0;
    o_err    = 1'b0;
    case (i_seg)
      SEG_HEX_0: o_nibble = 4'h0;
      SEG_HEX_1: o_nibble = 4'h1;
      SEG_HEX_2: o_nibble = 4'h2;
      SEG_HEX_3: o_nibble = 4'h3;
      SEG_HEX_4: o_nibble = 4'h4;
      SEG_HEX_5: o_nibble = 4'h5;
      SEG_HEX_6: o_nibble = 4'h6;
      SEG_HEX_7: o_nibble = 4'h7;
      SEG_HEX_8: o_nibble = 4'h8;
      SEG_HEX_9: o_nibble = 4'h9;
      SEG_HEX_A: o_nibble = 4'hA;
      SEG_HEX_B: o_nibble = 4'hB;
      SEG_HEX_C: o_nibble = 4'hC;
      SEG_HEX_D: o_nibble = 4'hD;
      SEG_HEX_E: o_nibble = 4'hE;
      SEG_HEX_F: o_nibble = 4'hF;
      SEG_BLANK: o_blank  = 1'b1;
      SEG_MINUS: o_minus  = 1'b1;
      default:   o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan monitor; SEG_DP_CAPTURE_EN adds dp_mask output
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
)
(
  input  logic        clkin,
  input  logic        btnR,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic [3:0]  minus_mask,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        scan_stall
`ifdef SEG_DP_CAPTURE_EN
  ,
  output logic [3:0]  dp_mask
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [10:0]       r_sync [SYNC_STAGES];
  logic [10:0]       r_prev;
  scan_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0][3:0]   r_sh_nib;
  logic [3:0]        r_sh_blank;
  logic [3:0]        r_sh_minus;
  logic [3:0]        r_sh_err;
  logic [3:0]        r_pending;
  logic [TMO_W-1:0]  r_tmo;
  logic [15:0]       r_value;
  logic [3:0]        r_blank_mask;
  logic [3:0]        r_minus_mask;
  logic              r_frame_valid;
  logic              r_frame_err;
  logic              r_scan_stall;

  logic [3:0]        w_an;
  logic [6:0]        w_seg;
  logic              w_changed;
  logic              w_onehot;
  logic [1:0]        w_idx;
  logic              w_capture;
  logic              w_commit;
  logic              w_stall_hit;
  logic [3:0]        w_cap_bit;
  logic [3:0]        w_pending_nxt;
  logic [3:0]        w_nib;
  logic              w_blank;
  logic              w_minus;
  logic              w_err;

  // Synchronise the anode/segment bus; idle value is all segments and anodes off
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
      r_prev <= '1;
    end else begin
      r_sync[0] <= {an, seg};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_an      = r_sync[SYNC_STAGES-1][10:7];
  assign w_seg     = r_sync[SYNC_STAGES-1][6:0];
  assign w_changed = (r_sync[SYNC_STAGES-1] != r_prev);
  assign w_onehot  = an_onehot_low(w_an);
  assign w_idx     = an_index(w_an);

  seg7_to_hex u_dec (
    .i_seg    (w_seg),
    .o_nibble (w_nib),
    .o_blank  (w_blank),
    .o_minus  (w_minus),
    .o_err    (w_err)
  );

  // The sample that makes the run STABLE_CYCLES long is the one captured
  assign w_capture = (r_state == ST_SETTLE) && !w_changed && (r_cnt == STABLE_LAST);

  // Per-dwell FSM: wait for one anode, count identical samples, then hold until the bus moves
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_onehot) begin
            r_state <= ST_SETTLE;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_changed) begin
            r_state <= w_onehot ? ST_SETTLE : ST_WAIT;
            r_cnt   <= w_onehot ? CNT_W'(1) : '0;
          end else if (w_capture) begin
            r_state <= ST_HELD;
            r_cnt   <= r_cnt + 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (w_changed) begin
            r_state <= w_onehot ? ST_SETTLE : ST_WAIT;
            r_cnt   <= w_onehot ? CNT_W'(1) : '0;
          end
        end
        default: begin
          r_state <= ST_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_commit      = (r_pending == 4'b1111);
  assign w_cap_bit     = w_capture ? (4'b0001 << w_idx) : 4'b0000;
  assign w_stall_hit   = !w_capture && (r_tmo == TMO_LAST);
  assign w_pending_nxt = w_stall_hit ? 4'b0000
                                     : ((w_commit ? 4'b0000 : r_pending) | w_cap_bit);

  // Shadow capture, atomic frame commit and scan-stall watchdog
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      r_sh_nib      <= '0;
      r_sh_blank    <= '0;
      r_sh_minus    <= '0;
      r_sh_err      <= '0;
      r_pending     <= '0;
      r_tmo         <= '0;
      r_value       <= '0;
      r_blank_mask  <= '0;
      r_minus_mask  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_scan_stall  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sh_nib[w_idx]   <= w_nib;
        r_sh_blank[w_idx] <= w_blank;
        r_sh_minus[w_idx] <= w_minus;
        r_sh_err[w_idx]   <= w_err;
      end
      r_pending     <= w_pending_nxt;
      r_frame_valid <= w_commit;
      if (w_commit) begin
        r_value      <= r_sh_nib;
        r_blank_mask <= r_sh_blank;
        r_minus_mask <= r_sh_minus;
        r_frame_err  <= |r_sh_err;
      end
      if (w_capture) begin
        r_tmo        <= '0;
        r_scan_stall <= 1'b0;
      end else if (w_stall_hit) begin
        r_scan_stall <= 1'b1;
      end else begin
        r_tmo        <= r_tmo + 1'b1;
      end
    end
  end

  assign value       = r_value;
  assign blank_mask  = r_blank_mask;
  assign minus_mask  = r_minus_mask;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign scan_stall  = r_scan_stall;

`ifdef SEG_DP_CAPTURE_EN
  logic [SYNC_STAGES-1:0] r_dp_sync;
  logic [3:0]             r_sh_dp;
  logic [3:0]             r_dp_mask;

  // Decimal point follows its digit through capture and commit (lit = low)
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      r_dp_sync <= '1;
      r_sh_dp   <= '0;
      r_dp_mask <= '0;
    end else begin
      r_dp_sync[0] <= dp;
      for (int i = 1; i < SYNC_STAGES; i++) r_dp_sync[i] <= r_dp_sync[i-1];
      if (w_capture) r_sh_dp[w_idx] <= ~r_dp_sync[SYNC_STAGES-1];
      if (w_commit)  r_dp_mask      <= r_sh_dp;
    end
  end

  assign dp_mask = r_dp_mask;
`else
  logic w_unused_dp;
  assign w_unused_dp = dp;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clkin = 1'b0;
  logic        btnR  = 1'b1;
  logic [6:0]  seg   = 7'h7f;
  logic [3:0]  an    = 4'hf;
  logic        dp    = 1'b1;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  minus_mask;
  logic        frame_valid;
  logic        frame_err;
  logic        scan_stall;
`ifdef SEG_DP_CAPTURE_EN
  logic [3:0]  dp_mask;
`endif

  seg_scan_decoder #(
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clkin       (clkin),
    .btnR        (btnR),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .value       (value),
    .blank_mask  (blank_mask),
    .minus_mask  (minus_mask),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .scan_stall  (scan_stall)
`ifdef SEG_DP_CAPTURE_EN
    ,
    .dp_mask     (dp_mask)
`endif
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  b;
    logic [3:0]  m;
    logic        e;
  } frame_t;

  frame_t     sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         frames = 0;
  logic [6:0] hex_pat [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t model(input logic [27:0] pats);
    frame_t     f;
    logic [6:0] p;
    logic       hit;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      p   = pats[7*i +: 7];
      hit = 1'b0;
      if (p == 7'b1111111) f.b[i] = 1'b1;
      else if (p == 7'b0111111) f.m[i] = 1'b1;
      else begin
        for (int n = 0; n < 16; n++)
          if (hex_pat[n] == p) begin
            f.v[4*i +: 4] = n[3:0];
            hit = 1'b1;
          end
        if (!hit) f.e = 1'b1;
      end
    end
    return f;
  endfunction

  // Every published frame must match the oldest expected frame
  always @(negedge clkin) begin
    frame_t f;
    if (frame_valid === 1'b1) begin
      frames++;
      if (sb_q.size() == 0) check("unexpected_frame", 32'(sb_q.size()), 32'd1);
      else begin
        f = sb_q.pop_front();
        check("frame_value", 32'(value), 32'(f.v));
        check("frame_blank", 32'(blank_mask), 32'(f.b));
        check("frame_minus", 32'(minus_mask), 32'(f.m));
        check("frame_err", 32'(frame_err), 32'(f.e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic dwell(input int d, input logic [6:0] p, input int cycles, input bit glitch);
    an = ~(4'b0001 << d);
    if (glitch) begin
      seg = 7'b0000000;
      tick(1);
      seg = p;
      tick(cycles - 1);
    end else begin
      seg = p;
      tick(cycles);
    end
  endtask

  task automatic idle(input int n);
    an  = 4'hf;
    seg = 7'h7f;
    tick(n);
  endtask

  task automatic scan(input logic [27:0] pats, input int cycles, input bit glitch, input bit exp_frame);
    if (exp_frame) sb_q.push_back(model(pats));
    for (int i = 0; i < 4; i++) dwell(i, pats[7*i +: 7], cycles, glitch);
    idle(4);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_value"}, 32'(value), 32'd0);
    check({tag, "_masks"}, 32'({blank_mask, minus_mask}), 32'd0);
    check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_stall"}, 32'(scan_stall), 32'd0);
  endtask

  initial begin
    logic [15:0] v_before;
    int          fr_before;
    logic [27:0] pats;

    hex_pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    tick(3);
    check_reset_state("rst");
    btnR = 1'b0;
    tick(3);

    // T1: digits 0,0,1,7
    scan({hex_pat[0], hex_pat[0], hex_pat[1], hex_pat[7]}, 10, 1'b0, 1'b1);
    check("t1_frames", 32'(frames), 32'd1);

    // T2: minus, E, 9, blank from left to right
    scan({7'b0111111, hex_pat[14], hex_pat[9], 7'b1111111}, 10, 1'b0, 1'b1);
    check("t2_frames", 32'(frames), 32'd2);

    // T3: glitch at every anode change with dwells too short to capture
    fr_before = frames;
    scan({hex_pat[5], hex_pat[10], hex_pat[3], hex_pat[12]}, 4, 1'b1, 1'b0);
    idle(10);
    check("t3_short_noframe", 32'(frames), 32'(fr_before));
    scan({hex_pat[5], hex_pat[10], hex_pat[3], hex_pat[12]}, 10, 1'b1, 1'b1);
    check("t3_frames", 32'(frames), 32'(fr_before + 1));

    // T4: undecodable digit1, then a two-anode hold inside a frame
    scan({hex_pat[2], hex_pat[4], 7'b1010101, hex_pat[6]}, 10, 1'b0, 1'b1);
    pats = {hex_pat[3], hex_pat[9], hex_pat[5], hex_pat[1]};
    sb_q.push_back(model(pats));
    fr_before = frames;
    for (int i = 0; i < 3; i++) dwell(i, pats[7*i +: 7], 10, 1'b0);
    an  = 4'b1100;
    seg = hex_pat[15];
    tick(20);
    check("t4_hold_noframe", 32'(frames), 32'(fr_before));
    dwell(3, pats[21 +: 7], 10, 1'b0);
    idle(4);
    check("t4_frames", 32'(frames), 32'(fr_before + 1));

    // T5: scan stall with all anodes off, then recovery
    v_before = value;
    idle(30);
    check("t5_stall_early", 32'(scan_stall), 32'd0);
    idle(70);
    check("t5_stall_set", 32'(scan_stall), 32'd1);
    check("t5_value_held", 32'(value), 32'(v_before));
    pats = {hex_pat[13], hex_pat[12], hex_pat[11], hex_pat[10]};
    sb_q.push_back(model(pats));
    fr_before = frames;
    dwell(0, pats[6:0], 10, 1'b0);
    check("t5_stall_clear", 32'(scan_stall), 32'd0);
    for (int i = 1; i < 4; i++) dwell(i, pats[7*i +: 7], 10, 1'b0);
    idle(4);
    check("t5_frames", 32'(frames), 32'(fr_before + 1));

    // T6: reset after three captures, then a fresh frame needs four new captures
    for (int i = 0; i < 3; i++) dwell(i, hex_pat[8 + i], 10, 1'b0);
    #2;
    btnR = 1'b1;
    #1;
    check_reset_state("t6_async");
    an  = 4'hf;
    seg = 7'h7f;
    tick(2);
    btnR = 1'b0;
    tick(3);
    pats = {hex_pat[4], hex_pat[15], hex_pat[2], hex_pat[6]};
    fr_before = frames;
    for (int i = 0; i < 3; i++) dwell(i, pats[7*i +: 7], 10, 1'b0);
    check("t6_partial_noframe", 32'(frames), 32'(fr_before));
    sb_q.push_back(model(pats));
    dwell(3, pats[21 +: 7], 10, 1'b0);
    idle(4);
    check("t6_frames", 32'(frames), 32'(fr_before + 1));

    idle(5);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
